// File: rtl/vx_mem_bus_arb.sv
// Round-robin N:1 memory bus arbiter with a 2-entry request skid buffer and tag-routed responses.
// Define MEM_BUS_ARB_PERF_EN to add the perf_req_count / perf_stall_count outputs.
module vx_mem_bus_arb #(
    parameter int NUM_INPUTS  = 4,
    parameter int DATA_SIZE   = 64,
    parameter int ADDR_WIDTH  = 26,
    parameter int FLAGS_WIDTH = 4,
    parameter int TAG_WIDTH   = 8,
    localparam int LOG_N      = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 0,
    localparam int OUT_TAG_W  = TAG_WIDTH + LOG_N,
    localparam int REQ_W      = 1 + ADDR_WIDTH + DATA_SIZE * 8 + DATA_SIZE + FLAGS_WIDTH + TAG_WIDTH,
    localparam int OUT_REQ_W  = REQ_W - TAG_WIDTH + OUT_TAG_W,
    localparam int RSP_W      = DATA_SIZE * 8 + TAG_WIDTH,
    localparam int OUT_RSP_W  = DATA_SIZE * 8 + OUT_TAG_W
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [NUM_INPUTS-1:0]       in_req_valid,
    input  logic [NUM_INPUTS*REQ_W-1:0] in_req_data,
    output logic [NUM_INPUTS-1:0]       in_req_ready,
    output logic [NUM_INPUTS-1:0]       in_rsp_valid,
    output logic [NUM_INPUTS*RSP_W-1:0] in_rsp_data,
    input  logic [NUM_INPUTS-1:0]       in_rsp_ready,
    output logic                        out_req_valid,
    output logic [OUT_REQ_W-1:0]        out_req_data,
    input  logic                        out_req_ready,
    input  logic                        out_rsp_valid,
    input  logic [OUT_RSP_W-1:0]        out_rsp_data,
    output logic                        out_rsp_ready
`ifdef MEM_BUS_ARB_PERF_EN
    ,
    output logic [31:0]                 perf_req_count,
    output logic [31:0]                 perf_stall_count
`endif
);

    localparam int PTR_W = (LOG_N > 0) ? LOG_N : 1;

    logic [PTR_W-1:0]     rr_ptr;
    logic [PTR_W-1:0]     grant_idx;
    logic [PTR_W-1:0]     next_ptr;
    logic                 grant_valid;
    logic [REQ_W-1:0]     grant_req;
    logic [OUT_REQ_W-1:0] push_data;

    logic [OUT_REQ_W-1:0] slot0;
    logic [OUT_REQ_W-1:0] slot1;
    logic [1:0]           count;
    logic                 active;
    logic                 full;
    logic                 push;
    logic                 pop;

    // Scanning downward leaves the lowest valid index in each candidate; the
    // at-or-above-pointer candidate wins, otherwise the search wraps to 0.
    always_comb begin
        logic             hi_found;
        logic             lo_found;
        logic [PTR_W-1:0] hi_idx;
        logic [PTR_W-1:0] lo_idx;
        hi_found = 1'b0;
        lo_found = 1'b0;
        hi_idx   = '0;
        lo_idx   = '0;
        for (int i = NUM_INPUTS - 1; i >= 0; i--) begin
            if (in_req_valid[i]) begin
                lo_found = 1'b1;
                lo_idx   = PTR_W'(i);
                if (i >= int'(rr_ptr)) begin
                    hi_found = 1'b1;
                    hi_idx   = PTR_W'(i);
                end
            end
        end
        grant_valid = lo_found;
        grant_idx   = hi_found ? hi_idx : lo_idx;
    end

    assign grant_req = in_req_data[int'(grant_idx)*REQ_W +: REQ_W];
    assign next_ptr  = (int'(grant_idx) == NUM_INPUTS - 1) ? '0 : grant_idx + 1'b1;

    if (LOG_N > 0) begin : g_widen_tag
        assign push_data = {grant_req, grant_idx};
    end else begin : g_pass_tag
        assign push_data = grant_req;
    end

    // Ready is a function of registered buffer state only; active blocks
    // grants during the first cycle after reset.
    assign full          = (count == 2'd2);
    assign push          = grant_valid && active && !full;
    assign out_req_valid = (count != 2'd0);
    assign out_req_data  = slot0;
    assign pop           = out_req_valid && out_req_ready;

    always_comb begin
        in_req_ready = '0;
        if (push) begin
            in_req_ready[grant_idx] = 1'b1;
        end
    end

    // slot0 is always the head; push+pop only happens with one entry held.
    always_ff @(posedge clk) begin
        if (!reset) begin
            count  <= 2'd0;
            rr_ptr <= '0;
            active <= 1'b0;
        end else begin
            active <= 1'b1;
            if (push) begin
                rr_ptr <= next_ptr;
            end
            case ({push, pop})
                2'b10: begin
                    if (count == 2'd0) begin
                        slot0 <= push_data;
                    end else begin
                        slot1 <= push_data;
                    end
                    count <= count + 2'd1;
                end
                2'b01: begin
                    slot0 <= slot1;
                    count <= count - 2'd1;
                end
                2'b11: begin
                    slot0 <= push_data;
                end
                default: begin
                end
            endcase
        end
    end

    logic [PTR_W-1:0] rsp_idx;
    logic [RSP_W-1:0] rsp_body;
    logic             rsp_idx_ok;

    if (LOG_N > 0) begin : g_rsp_split
        assign rsp_idx  = out_rsp_data[LOG_N-1:0];
        assign rsp_body = out_rsp_data[OUT_RSP_W-1:LOG_N];
    end else begin : g_rsp_pass
        assign rsp_idx  = '0;
        assign rsp_body = out_rsp_data;
    end

    assign rsp_idx_ok  = (int'(rsp_idx) < NUM_INPUTS);
    assign in_rsp_data = {NUM_INPUTS{rsp_body}};

    // Responses to a non-existent channel are swallowed rather than stalling the bus.
    always_comb begin
        in_rsp_valid  = '0;
        out_rsp_ready = 1'b1;
        if (rsp_idx_ok) begin
            in_rsp_valid[rsp_idx] = out_rsp_valid;
            out_rsp_ready         = in_rsp_ready[rsp_idx];
        end
    end

    always_ff @(posedge clk) begin
        if (reset && out_rsp_valid) begin
            assert (rsp_idx_ok);
        end
    end

`ifdef MEM_BUS_ARB_PERF_EN
    always_ff @(posedge clk) begin
        if (!reset) begin
            perf_req_count   <= '0;
            perf_stall_count <= '0;
        end else begin
            if (pop) begin
                perf_req_count <= perf_req_count + 32'd1;
            end
            if (out_req_valid && !out_req_ready) begin
                perf_stall_count <= perf_stall_count + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_vx_mem_bus_arb.sv
// Directed self-checking bench for vx_mem_bus_arb with NUM_INPUTS=4, TAG_WIDTH=4.
module tb_vx_mem_bus_arb;

    localparam int N         = 4;
    localparam int REQ_W     = 51;
    localparam int OUT_REQ_W = 53;
    localparam int RSP_W     = 36;
    localparam int OUT_RSP_W = 38;

    logic                 clk = 1'b0;
    logic                 reset;
    logic [N-1:0]         in_req_valid;
    logic [N*REQ_W-1:0]   in_req_data;
    logic [N-1:0]         in_req_ready;
    logic [N-1:0]         in_rsp_valid;
    logic [N*RSP_W-1:0]   in_rsp_data;
    logic [N-1:0]         in_rsp_ready;
    logic                 out_req_valid;
    logic [OUT_REQ_W-1:0] out_req_data;
    logic                 out_req_ready;
    logic                 out_rsp_valid;
    logic [OUT_RSP_W-1:0] out_rsp_data;
    logic                 out_rsp_ready;
`ifdef MEM_BUS_ARB_PERF_EN
    logic [31:0]          perf_req_count;
    logic [31:0]          perf_stall_count;
`endif

    logic [REQ_W-1:0] req_in [N];
    assign in_req_data = {req_in[3], req_in[2], req_in[1], req_in[0]};

    int checks = 0;
    int errors = 0;

    vx_mem_bus_arb #(
        .NUM_INPUTS (4),
        .DATA_SIZE  (4),
        .ADDR_WIDTH (8),
        .FLAGS_WIDTH(2),
        .TAG_WIDTH  (4)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .in_req_valid (in_req_valid),
        .in_req_data  (in_req_data),
        .in_req_ready (in_req_ready),
        .in_rsp_valid (in_rsp_valid),
        .in_rsp_data  (in_rsp_data),
        .in_rsp_ready (in_rsp_ready),
        .out_req_valid(out_req_valid),
        .out_req_data (out_req_data),
        .out_req_ready(out_req_ready),
        .out_rsp_valid(out_rsp_valid),
        .out_rsp_data (out_rsp_data),
        .out_rsp_ready(out_rsp_ready)
`ifdef MEM_BUS_ARB_PERF_EN
        ,
        .perf_req_count  (perf_req_count),
        .perf_stall_count(perf_stall_count)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [REQ_W-1:0] mk_req(input logic rw, input logic [7:0] addr,
                                                input logic [31:0] data, input logic [3:0] be,
                                                input logic [1:0] flags, input logic [3:0] tag);
        return {rw, addr, data, be, flags, tag};
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        reset         = 1'b0;
        in_req_valid  = 4'b1111;
        out_req_ready = 1'b1;
        out_rsp_valid = 1'b0;
        out_rsp_data  = '0;
        in_rsp_ready  = 4'b0000;
        for (int i = 0; i < N; i++) req_in[i] = '0;
        tick;
        tick;
        #1;
        checks++;
        if (out_req_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_out_valid: got %b expected 0", out_req_valid);
        end
        checks++;
        if (in_req_ready !== 4'b0000) begin
            errors++;
            $display("[TB] FAIL reset_in_ready: got %b expected 0000", in_req_ready);
        end
        in_req_valid = 4'b0000;
        reset        = 1'b1;
        tick;
    endtask

    task automatic test_round_robin;
        for (int i = 0; i < N; i++)
            req_in[i] = mk_req(i[0], 8'(8'h10 + i), 32'hA000_0000 + i, 4'hF, 2'(i), 4'(4'h8 + i));
        in_req_valid  = 4'b1111;
        out_req_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            #1;
            checks++;
            if (in_req_ready !== 4'(1 << (k % 4))) begin
                errors++;
                $display("[TB] FAIL rr_grant k=%0d: got %b expected %b", k, in_req_ready, 4'(1 << (k % 4)));
            end
            if (k > 0) begin
                checks++;
                if (out_req_data !== {req_in[(k - 1) % 4], 2'((k - 1) % 4)}) begin
                    errors++;
                    $display("[TB] FAIL rr_out_data k=%0d: got %h expected %h", k, out_req_data,
                             {req_in[(k - 1) % 4], 2'((k - 1) % 4)});
                end
            end
            tick;
        end
        #1;
        checks++;
        if (out_req_valid !== 1'b1 || out_req_data !== {req_in[0], 2'd0}) begin
            errors++;
            $display("[TB] FAIL rr_out_wrap: got v=%b %h expected v=1 %h", out_req_valid, out_req_data,
                     {req_in[0], 2'd0});
        end
        in_req_valid = 4'b0000;
        tick;
        checks++;
        if (out_req_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL rr_drain: got %b expected 0", out_req_valid);
        end
    endtask

    task automatic test_single_channel;
        req_in[2]    = mk_req(1'b1, 8'h55, 32'h1234_5678, 4'hC, 2'd3, 4'h5);
        in_req_valid = 4'b0100;
        #1;
        checks++;
        if (in_req_ready !== 4'b0100) begin
            errors++;
            $display("[TB] FAIL single_grant: got %b expected 0100", in_req_ready);
        end
        tick;
        in_req_valid = 4'b0000;
        #1;
        checks++;
        if (out_req_valid !== 1'b1 || out_req_data[5:0] !== 6'h16) begin
            errors++;
            $display("[TB] FAIL single_tag: got v=%b tag=%h expected v=1 tag=16", out_req_valid, out_req_data[5:0]);
        end
        checks++;
        if (out_req_data !== {1'b1, 8'h55, 32'h1234_5678, 4'hC, 2'd3, 4'h5, 2'd2}) begin
            errors++;
            $display("[TB] FAIL single_payload: got %h expected %h", out_req_data,
                     {1'b1, 8'h55, 32'h1234_5678, 4'hC, 2'd3, 4'h5, 2'd2});
        end
        tick;
    endtask

    task automatic test_backpressure;
        logic [N-1:0] got;
        int           acc;
        int           pos;
        int           ord [3];
        ord = '{3, 0, 1};
        req_in[0]     = mk_req(1'b0, 8'hA0, 32'h0000_00A0, 4'h1, 2'd0, 4'h1);
        req_in[1]     = mk_req(1'b1, 8'hA1, 32'h0000_00A1, 4'h2, 2'd1, 4'h2);
        req_in[3]     = mk_req(1'b0, 8'hA3, 32'h0000_00A3, 4'h8, 2'd2, 4'h3);
        out_req_ready = 1'b0;
        in_req_valid  = 4'b1011;
        acc           = 0;
        for (int c = 0; c < 5; c++) begin
            #1;
            got = in_req_ready & in_req_valid;
            acc += $countones(got);
            if (c == 0) begin
                checks++;
                if (in_req_ready !== 4'b1000) begin
                    errors++;
                    $display("[TB] FAIL bp_first_grant: got %b expected 1000", in_req_ready);
                end
            end
            if (c == 1) begin
                checks++;
                if (in_req_ready !== 4'b0001) begin
                    errors++;
                    $display("[TB] FAIL bp_second_grant: got %b expected 0001", in_req_ready);
                end
            end
            if (c >= 1) begin
                checks++;
                if (out_req_valid !== 1'b1 || out_req_data !== {req_in[3], 2'd3}) begin
                    errors++;
                    $display("[TB] FAIL bp_stable c=%0d: got v=%b %h expected v=1 %h", c, out_req_valid,
                             out_req_data, {req_in[3], 2'd3});
                end
            end
            tick;
            in_req_valid = in_req_valid & ~got;
        end
        #1;
        checks++;
        if (acc !== 2) begin
            errors++;
            $display("[TB] FAIL bp_accept_count: got %0d expected 2", acc);
        end
        checks++;
        if (in_req_ready !== 4'b0000) begin
            errors++;
            $display("[TB] FAIL bp_full_ready: got %b expected 0000", in_req_ready);
        end
        out_req_ready = 1'b1;
        pos           = 0;
        for (int c = 0; c < 10 && pos < 3; c++) begin
            #1;
            got = in_req_ready & in_req_valid;
            if (out_req_valid) begin
                checks++;
                if (out_req_data !== {req_in[ord[pos]], 2'(ord[pos])}) begin
                    errors++;
                    $display("[TB] FAIL bp_order pos=%0d: got %h expected %h", pos, out_req_data,
                             {req_in[ord[pos]], 2'(ord[pos])});
                end
                pos++;
            end
            tick;
            in_req_valid = in_req_valid & ~got;
        end
        checks++;
        if (pos !== 3) begin
            errors++;
            $display("[TB] FAIL bp_drain_count: got %0d expected 3", pos);
        end
        #1;
        checks++;
        if (out_req_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL bp_empty: got %b expected 0", out_req_valid);
        end
    endtask

    task automatic test_response;
        out_rsp_data  = {32'hDEAD_BEEF, 6'h2D};
        out_rsp_valid = 1'b1;
        in_rsp_ready  = 4'b0000;
        #1;
        checks++;
        if (in_rsp_valid !== 4'b0010) begin
            errors++;
            $display("[TB] FAIL rsp_valid_route: got %b expected 0010", in_rsp_valid);
        end
        checks++;
        if (in_rsp_data[RSP_W +: RSP_W] !== {32'hDEAD_BEEF, 4'hB}) begin
            errors++;
            $display("[TB] FAIL rsp_data_strip: got %h expected %h", in_rsp_data[RSP_W +: RSP_W],
                     {32'hDEAD_BEEF, 4'hB});
        end
        checks++;
        if (out_rsp_ready !== 1'b0) begin
            errors++;
            $display("[TB] FAIL rsp_ready_low: got %b expected 0", out_rsp_ready);
        end
        in_rsp_ready = 4'b1101;
        #1;
        checks++;
        if (out_rsp_ready !== 1'b0) begin
            errors++;
            $display("[TB] FAIL rsp_ready_other: got %b expected 0", out_rsp_ready);
        end
        in_rsp_ready = 4'b0010;
        #1;
        checks++;
        if (out_rsp_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL rsp_ready_high: got %b expected 1", out_rsp_ready);
        end
        out_rsp_valid = 1'b0;
        #1;
        checks++;
        if (in_rsp_valid !== 4'b0000) begin
            errors++;
            $display("[TB] FAIL rsp_idle: got %b expected 0000", in_rsp_valid);
        end
        in_rsp_ready = 4'b0000;
    endtask

    task automatic test_reset_midflight;
        logic [N-1:0] got;
        req_in[0]     = mk_req(1'b0, 8'hB0, 32'h0000_00B0, 4'h1, 2'd0, 4'h7);
        req_in[1]     = mk_req(1'b0, 8'hB1, 32'h0000_00B1, 4'h1, 2'd0, 4'h9);
        out_req_ready = 1'b0;
        in_req_valid  = 4'b0011;
        for (int c = 0; c < 2; c++) begin
            #1;
            got = in_req_ready & in_req_valid;
            tick;
            in_req_valid = in_req_valid & ~got;
        end
        in_req_valid = 4'b1000;
        #1;
        checks++;
        if (out_req_valid !== 1'b1 || in_req_ready !== 4'b0000) begin
            errors++;
            $display("[TB] FAIL mid_full: got v=%b rdy=%b expected v=1 rdy=0000", out_req_valid, in_req_ready);
        end
        reset = 1'b0;
        tick;
        #1;
        checks++;
        if (out_req_valid !== 1'b0 || in_req_ready !== 4'b0000) begin
            errors++;
            $display("[TB] FAIL mid_reset: got v=%b rdy=%b expected v=0 rdy=0000", out_req_valid, in_req_ready);
        end
`ifdef MEM_BUS_ARB_PERF_EN
        checks++;
        if (perf_req_count !== 32'd0 || perf_stall_count !== 32'd0) begin
            errors++;
            $display("[TB] FAIL mid_perf_zero: got %0d/%0d expected 0/0", perf_req_count, perf_stall_count);
        end
`endif
        in_req_valid = 4'b0000;
        reset        = 1'b1;
        tick;
        in_req_valid = 4'b1111;
        #1;
        checks++;
        if (in_req_ready !== 4'b0001) begin
            errors++;
            $display("[TB] FAIL mid_ptr_zero: got %b expected 0001", in_req_ready);
        end
        in_req_valid  = 4'b0000;
        out_req_ready = 1'b1;
        tick;
    endtask

    task automatic test_back_to_back;
        int   pushed;
        int   popped;
        logic push_now;
        reset = 1'b0;
        tick;
        reset = 1'b1;
        tick;
        pushed = 0;
        popped = 0;
        for (int c = 0; c < 40 && popped < 10; c++) begin
            out_req_ready = !(c >= 3 && c <= 5);
            req_in[0]     = mk_req(1'b0, 8'(pushed), 32'hC0DE_0000 + pushed, 4'h3, 2'd1, 4'(pushed));
            in_req_valid  = (pushed < 10) ? 4'b0001 : 4'b0000;
            #1;
            push_now = in_req_ready[0];
            if (out_req_valid && out_req_ready) begin
                checks++;
                if (out_req_data !== {mk_req(1'b0, 8'(popped), 32'hC0DE_0000 + popped, 4'h3, 2'd1, 4'(popped)), 2'd0}) begin
                    errors++;
                    $display("[TB] FAIL b2b_data n=%0d: got %h expected %h", popped, out_req_data,
                             {mk_req(1'b0, 8'(popped), 32'hC0DE_0000 + popped, 4'h3, 2'd1, 4'(popped)), 2'd0});
                end
                popped++;
            end
            tick;
            if (push_now) pushed++;
        end
        in_req_valid  = 4'b0000;
        out_req_ready = 1'b1;
        checks++;
        if (popped !== 10) begin
            errors++;
            $display("[TB] FAIL b2b_count: got %0d expected 10", popped);
        end
`ifdef MEM_BUS_ARB_PERF_EN
        #1;
        checks++;
        if (perf_req_count !== 32'd10) begin
            errors++;
            $display("[TB] FAIL perf_req: got %0d expected 10", perf_req_count);
        end
        checks++;
        if (perf_stall_count !== 32'd3) begin
            errors++;
            $display("[TB] FAIL perf_stall: got %0d expected 3", perf_stall_count);
        end
`endif
    endtask

    initial begin
        test_reset;
        test_round_robin;
        test_single_channel;
        test_backpressure;
        test_response;
        test_reset_midflight;
        test_back_to_back;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not complete in time");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/vx_mem_bus_arb.md
VX_MEM_BUS_ARB -- requirements
Module: VX_mem_bus_arb

Interface
REQ-001 The block SHALL have parameter NUM_INPUTS, default 4, number of upstream request/response channels (>=1).
REQ-002 The block SHALL have parameter DATA_SIZE, default 64, data bytes per request.
REQ-003 The block SHALL have parameter ADDR_WIDTH, default 26, word address width.
REQ-004 The block SHALL have parameter FLAGS_WIDTH, default 4, request flags width.
REQ-005 The block SHALL have parameter TAG_WIDTH, default 8, upstream tag width.
REQ-006 The block SHALL derive LOG_N = clog2(NUM_INPUTS) (0 when NUM_INPUTS=1), OUT_TAG_W = TAG_WIDTH+LOG_N, and REQ_W = 1+ADDR_WIDTH+DATA_SIZE*8+DATA_SIZE+FLAGS_WIDTH+TAG_WIDTH.
REQ-007 The block SHALL use one clock; reset is synchronous and active-low.
REQ-008 clk  in  1  clock, all state on rising edge.
REQ-009 reset  in  1  synchronous, active-low reset.
REQ-010 in_req_valid  in  NUM_INPUTS  per-channel request valid.
REQ-011 in_req_data  in  NUM_INPUTS*REQ_W  per-channel packed {rw, addr, data, byteen, flags, tag}, MSB to LSB.
REQ-012 in_req_ready  out  NUM_INPUTS  per-channel request accept.
REQ-013 in_rsp_valid  out  NUM_INPUTS  per-channel response valid.
REQ-014 in_rsp_data  out  NUM_INPUTS*(DATA_SIZE*8+TAG_WIDTH)  per-channel packed {data, tag}.
REQ-015 in_rsp_ready  in  NUM_INPUTS  per-channel response accept.
REQ-016 out_req_valid / out_req_data / out_req_ready  out/out/in  1 / REQ_W-TAG_WIDTH+OUT_TAG_W / 1  merged downstream request, tag field widened to OUT_TAG_W.
REQ-017 out_rsp_valid / out_rsp_data / out_rsp_ready  in/in/out  1 / DATA_SIZE*8+OUT_TAG_W / 1  downstream response.

Function
REQ-018 Arbitration SHALL be round-robin: grant the lowest channel index >= rr_ptr with in_req_valid set, wrapping to 0.
REQ-019 rr_ptr SHALL advance to (granted index + 1) mod NUM_INPUTS only on an accepted transfer; otherwise it SHALL hold.
REQ-020 in_req_ready[i] SHALL be 1 only when i is granted and the output buffer has a free entry; at most one bit is set per cycle.
REQ-021 Output tag SHALL be {in tag, granted index[LOG_N-1:0]}; all other fields pass unchanged.
REQ-022 Requests SHALL pass through a 2-entry FIFO-ordered skid buffer: 1-cycle latency, one transfer per cycle sustained when out_req_ready=1.
REQ-023 in_req_ready SHALL depend only on registered buffer state (no combinational path from out_req_ready).
REQ-024 While out_req_valid=1 and out_req_ready=0, out_req_data SHALL remain stable.
REQ-025 Buffer full: all in_req_ready=0; simultaneous push and pop when full is not permitted; push and pop on a 1-entry buffer SHALL both occur.
REQ-026 Responses SHALL route combinationally: idx = out_rsp_tag[LOG_N-1:0]; in_rsp_valid[idx]=out_rsp_valid; out_rsp_ready=in_rsp_ready[idx]; tag LSBs stripped.
REQ-027 idx >= NUM_INPUTS SHALL drop the response (out_rsp_ready=1, no in_rsp_valid) and fire a simulation assertion.
REQ-028 NUM_INPUTS=1 SHALL degenerate to a buffered pass-through with unwidened tag.

Reset
REQ-029 While reset=0 at a clock edge: rr_ptr=0, buffer emptied, out_req_valid=0, in_req_ready=0 the following cycle; buffered requests mid-flight are discarded.
REQ-030 Response path is stateless and SHALL not be affected by reset beyond its inputs.

Configuration
REQ-031 With MEM_BUS_ARB_PERF_EN defined, the block SHALL add outputs perf_req_count (32, counts accepted downstream requests) and perf_stall_count (32, counts cycles with out_req_valid=1 and out_req_ready=0), both reset to 0, wrapping modulo 2^32.
REQ-032 Without MEM_BUS_ARB_PERF_EN the perf ports and counters SHALL be absent.

Verification (NUM_INPUTS=4, TAG_WIDTH=4)
REQ-033 All 4 channels valid, out_req_ready=1 -> grants 0,1,2,3,0 on consecutive cycles, out tag LSBs 0,1,2,3,0 one cycle later.
REQ-034 Only channel 2 valid, tag 0x5 -> out_req_tag=0x16 one cycle after acceptance.
REQ-035 Channels 0,1,3 valid, out_req_ready=0 for 5 cycles -> exactly 2 accepted, in_req_ready=0 thereafter, payload stable; on release order preserved, no loss.
REQ-036 out_rsp tag 0x2D, in_rsp_ready=4'b0000 -> in_rsp_valid=4'b0010, in_rsp tag 0xB, out_rsp_ready=0; raise in_rsp_ready[1] -> out_rsp_ready=1.
REQ-037 reset=0 while buffer holds 2 entries -> next cycle out_req_valid=0, rr_ptr=0, perf counters 0.
REQ-038 MEM_BUS_ARB_PERF_EN: 10 accepted requests with 3 stall cycles -> perf_req_count=10, perf_stall_count=3.
